led_pattern_gen: RTL

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

---
 rtl/led_pattern_gen.sv | 113 +++++++++++
 1 files changed

// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled step tick driving binary, Gray, scanner and blink patterns.
// Latency: tick one cycle after prescaler wrap; leds one cycle after the step or mode change.
// No backpressure; en=0 freezes prescaler and pattern state. LED_PATTERN_PWM_EN adds duty gating.
module led_pattern_gen #(
    parameter int N_LEDS = 8,
    parameter int DIV    = 262144,
    parameter int PRE_W  = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
`ifdef LED_PATTERN_PWM_EN
    input  logic [7:0]        duty,
`endif
    output logic              tick,
    output logic [N_LEDS-1:0] leds
);

    localparam int POS_W = (N_LEDS > 2) ? $clog2(N_LEDS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);

    logic [PRE_W-1:0]  pre;
    logic [N_LEDS-1:0] cnt;
    logic [POS_W-1:0]  pos;
    logic              dir;
    logic [N_LEDS-1:0] leds_q;
    logic [N_LEDS-1:0] leds_nxt;
    logic              step;

    // A step happens on the enabled cycle where the prescaler sits at its last value.
    assign step = en && (pre == PRE_LAST);

    // Prescaler, step tick and pattern state; all pattern state advances regardless of mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre  <= '0;
            cnt  <= '0;
            pos  <= '0;
            dir  <= 1'b0;
            tick <= 1'b0;
        end else begin
            tick <= step;
            if (en) begin
                if (step) begin
                    pre <= '0;
                end else begin
                    pre <= pre + 1'b1;
                end
            end
            if (step) begin
                cnt <= cnt + 1'b1;
                if (!dir) begin
                    if (pos == POS_LAST) begin
                        dir <= 1'b1;
                        pos <= pos - 1'b1;
                    end else begin
                        pos <= pos + 1'b1;
                    end
                end else begin
                    if (pos == '0) begin
                        dir <= 1'b0;
                        pos <= pos + 1'b1;
                    end else begin
                        pos <= pos - 1'b1;
                    end
                end
            end
        end
    end

    // Pattern decode from the current mode and state.
    always_comb begin
        leds_nxt = '0;
        case (mode)
            2'd0:    leds_nxt = cnt;
            2'd1:    leds_nxt = cnt ^ (cnt >> 1);
            2'd2:    leds_nxt[pos] = 1'b1;
            default: leds_nxt = {N_LEDS{cnt[0]}};
        endcase
    end

    // Pattern register reloaded every cycle so mode changes show after one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds_q <= '0;
        end else begin
            leds_q <= leds_nxt;
        end
    end

`ifdef LED_PATTERN_PWM_EN
    logic [7:0] pwm;
    logic       gate_q;

    // Free-running PWM counter and registered brightness gate; duty=255 means fully on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm    <= '0;
            gate_q <= 1'b0;
        end else begin
            pwm    <= pwm + 1'b1;
            gate_q <= (pwm < duty) || (duty == 8'hFF);
        end
    end

    assign leds = leds_q & {N_LEDS{gate_q}};
`else
    assign leds = leds_q;
`endif

endmodule
